prim_cmd_queue: RTL
===================

# prim_cmd_queue

Command front end for the primitive renderer. Buffers 16-bit primitive command words written by the host register interface in a small FIFO and issues them on the renderer's `cmd`/`cmd_valid` interface. An execute word is only issued when the renderer is idle, and is followed by a wait for the resulting draw to finish. Sits between the register-bus decode and the renderer, and lets the host queue coordinate, color and execute words back-to-back without polling busy.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 words (16).
- `START_TIMEOUT`, default 4: cycles to wait for renderer busy after an execute word before giving up.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `wr_i`  in  1  host write strobe; one word per asserted cycle.
- `data_i`  in  16  host command word; `[15:12]` opcode, `[11:0]` payload.
- `flush_i`  in  1  empties the FIFO and clears `overflow_o`.
- `busy_i`  in  1  renderer busy.
- `cmd_o`  out  16  command word to the renderer; registered.
- `cmd_valid_o`  out  1  one-cycle pulse per issued word.
- `full_o`  out  1  FIFO holds 2^DEPTH_LOG2 words.
- `level_o`  out  DEPTH_LOG2+1  current FIFO occupancy.
- `overflow_o`  out  1  sticky; a write was dropped.
- `idle_o`  out  1  FIFO empty, state ST_READY, and `busy_i` low.

## Operation
- Reset values: `cmd_o`=0, `cmd_valid_o`=0, `full_o`=0, `level_o`=0, `overflow_o`=0, `idle_o`=1. FIFO pointers are 0 and the state is ST_READY.
- FIFO write:
  - `wr_i` with not full stores `data_i` at the tail.
  - `wr_i` while `full_o` drops the word and sets `overflow_o`, even if a pop occurs in the same cycle.
- FIFO pop: happens only on an issue. A write and a pop in the same cycle leave `level_o` unchanged.
- `flush_i`:
  - Resets the pointers, sets `level_o`=0 and clears `overflow_o`.
  - Overrides `wr_i` in the same cycle; the write is dropped and overflow is not set.
  - Does not change the FSM state; an in-flight draw is still waited out.
- FSM:
  - **ST_READY**: if the FIFO is non-empty and `busy_i`=0, pop the head into `cmd_o` and pulse `cmd_valid_o`.
    - If `head[15:12]==xv::PR_EXECUTE`, go to ST_WAIT_START and clear the timeout counter.
    - Otherwise stay in ST_READY, so the next word can issue on the next cycle.
  - **ST_WAIT_START**: counter increments each cycle.
    - `busy_i`=1 goes to ST_WAIT_DONE.
    - Counter reaching START_TIMEOUT-1 with busy never seen goes to ST_READY. This covers an unknown primitive code that never raises busy.
  - **ST_WAIT_DONE**: `busy_i`=0 goes to ST_READY.
- Non-execute words are never issued while `busy_i`=1. The renderer's coordinate registers must not change mid-draw.
- Any opcode is forwarded unchanged; this block does no opcode validation except the execute check.
- `cmd_o` holds its last value between pulses.

## Timing
- Issue latency: a word written to an empty FIFO in ST_READY with `busy_i`=0 at cycle N appears with `cmd_valid_o` at cycle N+2. The FIFO write is at edge N+1 and the registered issue at edge N+2.
- Throughput: one non-execute word per cycle while idle.
- Execute: the next word issues no earlier than 1 cycle after `busy_i` falls, or 1 cycle after the timeout expires.
- `full_o`, `level_o` and `idle_o` are registered and reflect the state after the current edge.
- `reset_n_i` asserted mid-draw:
  - Outputs return to their reset values immediately (asynchronously).
  - The FIFO contents are discarded.
- The counter width is $clog2(START_TIMEOUT)+1, so it does not wrap within the wait.

## Structure
- Shared `xv` package: use the existing `xv::PR_EXECUTE` and related opcodes. Add `xv::PR_CMDQ_DEPTH_LOG2` as the default depth.
- Local state enum: ST_READY, ST_WAIT_START, ST_WAIT_DONE.
- One sub-module: `prim_cmd_fifo`, a synchronous single-clock FIFO with push, pop, flush, full, empty and level, using the same async active-low reset. The FSM and issue register live in `prim_cmd_queue`.

## Test plan
- **Back-to-back issue**: write 0x?064 (COORDX0), COORDY0, COLOR 0x0AB with `busy_i`=0 → three consecutive `cmd_valid_o` pulses, with `cmd_o` matching the words in order; `idle_o`=1 after the last.
- **Execute stall**: queue EXECUTE (line), then COORDX0=0x010; `busy_i` rises 2 cycles after the execute pulse and stays high 20 cycles → COORDX0 issues exactly 1 cycle after `busy_i` falls, never during busy.
- **Timeout**: EXECUTE with an unknown code and `busy_i` held 0 → the FSM returns to ST_READY after START_TIMEOUT (4) cycles and the next word issues on the following cycle.
- **Overflow**: `busy_i`=1, write 17 words → `full_o`=1 after 16, `level_o`=16, `overflow_o`=1. `flush_i` → `level_o`=0 and `overflow_o`=0.
- **Simultaneous write/pop at full**: 16 queued, then release busy while writing → `level_o` goes 16→15 (write dropped), and `overflow_o` is set.
- **Async reset mid-draw**: assert `reset_n_i`=0 in ST_WAIT_DONE with 5 words queued → all outputs at reset values before the next edge, and `level_o`=0 after release.

Source files
------------

// File: rtl/xv_pkg.sv
// Shared primitive-renderer definitions.
//   - Command word layout: [15:12] opcode, [11:0] payload.
//   - PR_* opcodes understood by the renderer.
//   - PR_CMDQ_DEPTH_LOG2: default depth of the command queue FIFO.
package xv;

    localparam logic [3:0] PR_COORDX0 = 4'h0;
    localparam logic [3:0] PR_COORDY0 = 4'h1;
    localparam logic [3:0] PR_COORDX1 = 4'h2;
    localparam logic [3:0] PR_COORDY1 = 4'h3;
    localparam logic [3:0] PR_COLOR   = 4'h4;
    localparam logic [3:0] PR_EXECUTE = 4'hF;

    // Primitive codes carried in the payload of an execute word.
    localparam logic [11:0] PR_LINE        = 12'h001;
    localparam logic [11:0] PR_FILLED_RECT = 12'h002;

    localparam int PR_CMDQ_DEPTH_LOG2 = 4;

    function automatic logic pr_is_execute(input logic [15:0] word);
        return word[15:12] == PR_EXECUTE;
    endfunction

endpackage

// File: rtl/prim_cmd_queue_fifo.sv
// prim_cmd_fifo: single-clock synchronous FIFO for 16-bit command words.
//   clk, reset_n_i   : clock, asynchronous active-low reset
//   push_i, data_i   : write request and word (ignored when full or flushing)
//   pop_i            : remove head (ignored when empty or flushing)
//   flush_i          : empty the FIFO; wins over push and pop
//   head_o           : word at the head
//   full_o, empty_o  : occupancy flags
//   level_o          : current occupancy (registered)
//   level_next_o     : occupancy after the coming edge
module prim_cmd_fifo
    import xv::*;
#(
    parameter int DEPTH_LOG2 = PR_CMDQ_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    input  logic                  push_i,
    input  logic [15:0]           data_i,
    input  logic                  pop_i,
    input  logic                  flush_i,
    output logic [15:0]           head_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic [DEPTH_LOG2:0]   level_next_o
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   LVL_ONE = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2:0]   LVL_MAX = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    logic [15:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  push_ok;
    logic                  pop_ok;

    assign full_o  = (count == LVL_MAX);
    assign empty_o = (count == '0);
    assign level_o = count;
    assign head_o  = mem[rd_ptr];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        level_next_o = count;
        if (flush_i) begin
            level_next_o = '0;
        end else if (push_ok && !pop_ok) begin
            level_next_o = count + LVL_ONE;
        end else if (pop_ok && !push_ok) begin
            level_next_o = count - LVL_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
            count <= level_next_o;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/prim_cmd_queue.sv
// prim_cmd_queue: buffers host primitive command words and issues them to
// the renderer. Execute words are issued only when the renderer is idle and
// are followed by a wait for the draw to start (bounded) and to finish.
//   clk, reset_n_i : clock, asynchronous active-low reset
//   wr_i, data_i   : host write strobe and command word
//   flush_i        : empty the queue and clear overflow
//   busy_i         : renderer busy
//   cmd_o          : registered command word, held between pulses
//   cmd_valid_o    : one-cycle pulse per issued word
//   full_o         : queue full
//   level_o        : queue occupancy
//   overflow_o     : sticky, a write was dropped
//   idle_o         : queue empty, ready state, renderer not busy
module prim_cmd_queue
    import xv::*;
#(
    parameter int DEPTH_LOG2    = PR_CMDQ_DEPTH_LOG2,
    parameter int START_TIMEOUT = 4
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                wr_i,
    input  logic [15:0]         data_i,
    input  logic                flush_i,
    input  logic                busy_i,
    output logic [15:0]         cmd_o,
    output logic                cmd_valid_o,
    output logic                full_o,
    output logic [DEPTH_LOG2:0] level_o,
    output logic                overflow_o,
    output logic                idle_o
);

    localparam int CW = $clog2(START_TIMEOUT) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(START_TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_READY,
        ST_WAIT_START,
        ST_WAIT_DONE
    } state_t;

    state_t              state, state_next;
    logic [CW-1:0]       cnt, cnt_next;
    logic                issue;
    logic                idle_next;
    logic [15:0]         head;
    logic                empty;
    logic [DEPTH_LOG2:0] level_next;

    prim_cmd_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .push_i       (wr_i),
        .data_i       (data_i),
        .pop_i        (issue),
        .flush_i      (flush_i),
        .head_o       (head),
        .full_o       (full_o),
        .empty_o      (empty),
        .level_o      (level_o),
        .level_next_o (level_next)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        issue      = 1'b0;
        case (state)
            ST_READY: begin
                if (!empty && !busy_i) begin
                    issue = 1'b1;
                    if (pr_is_execute(head)) begin
                        state_next = ST_WAIT_START;
                        cnt_next   = '0;
                    end
                end
            end
            ST_WAIT_START: begin
                if (busy_i) begin
                    state_next = ST_WAIT_DONE;
                end else if (cnt == TO_LAST) begin
                    // Renderer never started (e.g. unknown primitive code).
                    state_next = ST_READY;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!busy_i) state_next = ST_READY;
            end
            default: state_next = ST_READY;
        endcase
        // Registered idle reflects the queue and state after this edge.
        idle_next = (level_next == '0) && (state_next == ST_READY) && !busy_i;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= ST_READY;
            cnt         <= '0;
            cmd_o       <= '0;
            cmd_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            idle_o      <= 1'b1;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            cmd_valid_o <= issue;
            if (issue) cmd_o <= head;
            // A write at full is lost even if a pop frees a slot this cycle.
            if (flush_i)            overflow_o <= 1'b0;
            else if (wr_i && full_o) overflow_o <= 1'b1;
            idle_o <= idle_next;
        end
    end

endmodule
